// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring on magnitudes).
// One iteration per cycle, 32 cycles busy, then a single-cycle done pulse with HI/LO loaded.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        multOp,
  input  logic        divOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        divZero
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] booth_upper, booth_sum;
  logic [64:0] booth_next;
  logic [32:0] div_shift, div_trial;
  logic [31:0] div_rem, div_quo, quo_fix, rem_fix;
  logic        div_bit;

  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;

  // Booth step: the sum is kept 33 bits wide so the most negative multiplicand cannot overflow;
  // the extra bit becomes the sign shifted into the upper word.
  always_comb begin
    booth_upper = {acc_q[64], acc_q[64:33]};
    unique case (acc_q[1:0])
      2'b01:   booth_sum = booth_upper + {mcand_q[31], mcand_q};
      2'b10:   booth_sum = booth_upper - {mcand_q[31], mcand_q};
      default: booth_sum = booth_upper;
    endcase
    booth_next = {booth_sum, acc_q[32:1]};
  end

  // Restoring step: acc holds {unused, remainder, quotient}; dividend bits shift out of the top
  // of the quotient word while quotient bits shift in at the bottom.
  always_comb begin
    div_shift = {acc_q[63:32], acc_q[31]};
    div_trial = div_shift - {1'b0, mcand_q};
    div_bit   = ~div_trial[32];
    div_rem   = div_bit ? div_trial[31:0] : div_shift[31:0];
    div_quo   = {acc_q[30:0], div_bit};
    quo_fix   = neg_quo_q ? (~div_quo + 32'd1) : div_quo;
    rem_fix   = neg_rem_q ? (~div_rem + 32'd1) : div_rem;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (divOp) begin
          if (B == 32'd0) begin
            state_d    = StDone;
            div_zero_d = 1'b1;
          end else begin
            state_d   = StDiv;
            acc_d     = {1'b0, 32'd0, a_mag};
            mcand_d   = b_mag;
            neg_quo_d = A[31] ^ B[31];
            neg_rem_d = A[31];
            cnt_d     = 5'd0;
          end
        end else if (multOp) begin
          state_d = StMult;
          acc_d   = {32'd0, A, 1'b0};
          mcand_d = B;
          cnt_d   = 5'd0;
        end
      end
      StMult: begin
        acc_d = booth_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          hi_d    = booth_next[64:33];
          lo_d    = booth_next[32:1];
        end
      end
      StDiv: begin
        acc_d = {1'b0, div_rem, div_quo};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign busy    = (state_q == StMult) || (state_q == StDiv);
  assign done    = (state_q == StDone);
  assign divZero = div_zero_q;

endmodule
